// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared constants, opcode table and state enum for the UART command parser
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [7:0] OPC_START     = 8'h01;
  localparam logic [7:0] OPC_SET_DELAY = 8'h02;
  localparam logic [7:0] OPC_SET_KEY   = 8'h03;
  localparam logic [7:0] OPC_SET_PT    = 8'h04;
  localparam logic [7:0] OPC_SET_INC   = 8'h05;

  localparam logic [4:0] LEN_START     = 5'd0;
  localparam logic [4:0] LEN_SET_DELAY = 5'd1;
  localparam logic [4:0] LEN_SET_KEY   = 5'd16;
  localparam logic [4:0] LEN_SET_PT    = 5'd16;
  localparam logic [4:0] LEN_SET_INC   = 5'd1;

  localparam logic [2:0] ERR_OPCODE   = 3'd1;
  localparam logic [2:0] ERR_CHECKSUM = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
  localparam logic [2:0] ERR_BUSY     = 3'd4;
  localparam logic [2:0] ERR_RANGE    = 3'd5;
  localparam logic [7:0] ERR_PREFIX   = 8'hE0;

  localparam logic [7:0] DELAY_MAX = 8'd31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_PAYLOAD,
    ST_CHECKSUM
  } parser_state_e;

  function automatic logic opc_known(input logic [7:0] opc);
    return (opc >= OPC_START) && (opc <= OPC_SET_INC);
  endfunction

  function automatic logic [4:0] opc_len(input logic [7:0] opc);
    case (opc)
      OPC_SET_DELAY: return LEN_SET_DELAY;
      OPC_SET_KEY:   return LEN_SET_KEY;
      OPC_SET_PT:    return LEN_SET_PT;
      OPC_SET_INC:   return LEN_SET_INC;
      default:       return LEN_START;
    endcase
  endfunction

  function automatic logic [7:0] err_ack(input logic [2:0] code);
    return ERR_PREFIX | {5'd0, code};
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// rtl/byte_timeout.sv - inter-byte idle counter with clear, enable and terminal flag
module byte_timeout #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] TERM = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;

  // Counter parks on the terminal value; the parser leaves the frame on hit, which clears it.
  always_ff @(posedge clk) begin
    if (!rstn || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !hit_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit_o = (cnt_q == TERM);

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - framed command decoder: sync, opcode, payload, checksum -> control outputs and ack
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         TIMEOUT   = 50000,
  parameter logic [4:0] DELAY_RST = 5'd15
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         rx_dv,
  input  logic [7:0]   rx_byte,
  input  logic         busy,
  output logic         start,
  output logic [4:0]   delay,
  output logic         inc_mode,
  output logic [127:0] key,
  output logic         key_vld,
  output logic [127:0] pt,
  output logic         pt_vld,
  output logic         ack_vld,
  output logic [7:0]   ack_byte
);

  parser_state_e state_q, state_d;
  logic [7:0]   opc_q, opc_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [7:0]   xor_q, xor_d;
  logic [127:0] shadow_q, shadow_d;
  logic         start_q, start_d;
  logic [4:0]   delay_q, delay_d;
  logic         inc_q, inc_d;
  logic [127:0] key_q, key_d;
  logic         key_vld_q, key_vld_d;
  logic [127:0] pt_q, pt_d;
  logic         pt_vld_q, pt_vld_d;
  logic         ack_vld_q, ack_vld_d;
  logic [7:0]   ack_byte_q, ack_byte_d;
  logic         tmo_hit;

  byte_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (rx_dv || (state_q == ST_IDLE)),
    .en_i  (state_q != ST_IDLE),
    .hit_o (tmo_hit)
  );

  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    cnt_d      = cnt_q;
    xor_d      = xor_q;
    shadow_d   = shadow_q;
    start_d    = 1'b0;
    delay_d    = delay_q;
    inc_d      = inc_q;
    key_d      = key_q;
    key_vld_d  = 1'b0;
    pt_d       = pt_q;
    pt_vld_d   = 1'b0;
    ack_vld_d  = 1'b0;
    ack_byte_d = ack_byte_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_dv && (rx_byte == SYNC_BYTE)) state_d = ST_OPCODE;
      end
      ST_OPCODE: begin
        if (rx_dv) begin
          opc_d = rx_byte;
          xor_d = rx_byte;
          cnt_d = opc_len(rx_byte);
          if (!opc_known(rx_byte)) begin
            ack_vld_d  = 1'b1;
            ack_byte_d = err_ack(ERR_OPCODE);
            state_d    = ST_IDLE;
          end else if (opc_len(rx_byte) == 5'd0) begin
            state_d = ST_CHECKSUM;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_dv) begin
          shadow_d = {shadow_q[119:0], rx_byte};
          xor_d    = xor_q ^ rx_byte;
          cnt_d    = cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_d = ST_CHECKSUM;
        end
      end
      ST_CHECKSUM: begin
        if (rx_dv) begin
          state_d   = ST_IDLE;
          ack_vld_d = 1'b1;
          if (rx_byte != xor_q) begin
            ack_byte_d = err_ack(ERR_CHECKSUM);
          end else if ((opc_q == OPC_START) && busy) begin
            ack_byte_d = err_ack(ERR_BUSY);
          end else if ((opc_q == OPC_SET_DELAY) && (shadow_q[7:0] > DELAY_MAX)) begin
            ack_byte_d = err_ack(ERR_RANGE);
          end else begin
            ack_byte_d = opc_q;
            case (opc_q)
              OPC_START:     start_d = 1'b1;
              OPC_SET_DELAY: delay_d = shadow_q[4:0];
              OPC_SET_INC:   inc_d   = shadow_q[0];
              OPC_SET_KEY: begin
                key_d     = shadow_q;
                key_vld_d = 1'b1;
              end
              OPC_SET_PT: begin
                pt_d     = shadow_q;
                pt_vld_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A byte arriving on the timeout cycle wins; the hit only matters on a silent cycle.
    if ((state_q != ST_IDLE) && !rx_dv && tmo_hit) begin
      state_d    = ST_IDLE;
      ack_vld_d  = 1'b1;
      ack_byte_d = err_ack(ERR_TIMEOUT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      opc_q      <= '0;
      cnt_q      <= '0;
      xor_q      <= '0;
      shadow_q   <= '0;
      start_q    <= 1'b0;
      delay_q    <= DELAY_RST;
      inc_q      <= 1'b0;
      key_q      <= '0;
      key_vld_q  <= 1'b0;
      pt_q       <= '0;
      pt_vld_q   <= 1'b0;
      ack_vld_q  <= 1'b0;
      ack_byte_q <= '0;
    end else begin
      state_q    <= state_d;
      opc_q      <= opc_d;
      cnt_q      <= cnt_d;
      xor_q      <= xor_d;
      shadow_q   <= shadow_d;
      start_q    <= start_d;
      delay_q    <= delay_d;
      inc_q      <= inc_d;
      key_q      <= key_d;
      key_vld_q  <= key_vld_d;
      pt_q       <= pt_d;
      pt_vld_q   <= pt_vld_d;
      ack_vld_q  <= ack_vld_d;
      ack_byte_q <= ack_byte_d;
    end
  end

  assign start    = start_q;
  assign delay    = delay_q;
  assign inc_mode = inc_q;
  assign key      = key_q;
  assign key_vld  = key_vld_q;
  assign pt       = pt_q;
  assign pt_vld   = pt_vld_q;
  assign ack_vld  = ack_vld_q;
  assign ack_byte = ack_byte_q;

endmodule
